// File: rtl/cpu_controller.sv
// Multicycle control FSM: drives PC clear/increment, latches the fetched word into IR,
// and decodes (state, IR) into data-memory, register-file and ALU strobes.
module cpu_controller #(
  parameter int OPW = 4,
  parameter int IRW = 16
) (
  input  logic           Clock,
  input  logic           Clr,
  input  logic [IRW-1:0] Instr,
  output logic           PC_clr,
  output logic           PC_up,
  output logic [IRW-1:0] IR_out,
  output logic [7:0]     D_addr,
  output logic           D_wr,
  output logic           RF_s,
  output logic [3:0]     RF_W_addr,
  output logic           RF_W_en,
  output logic [3:0]     RF_Ra_addr,
  output logic [3:0]     RF_Rb_addr,
  output logic [2:0]     ALU_s0,
  output logic           Halted,
  output logic [3:0]     State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_NOOP  = 4'b0000;
  localparam logic [OPW-1:0] OP_STORE = 4'b0001;
  localparam logic [OPW-1:0] OP_LOAD  = 4'b0010;
  localparam logic [OPW-1:0] OP_ADD   = 4'b0011;
  localparam logic [OPW-1:0] OP_SUB   = 4'b0100;
  localparam logic [OPW-1:0] OP_HALT  = 4'b0101;

  state_t         state_q, state_d;
  logic [IRW-1:0] ir_q, ir_d;
  logic [OPW-1:0] opcode;

  assign opcode = ir_q[IRW-1 -: OPW];

  // Clr is synchronous and wins over every state, HALT included.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (Clr) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_d    = S_INIT;
    ir_d       = ir_q;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    Halted     = 1'b0;

    unique case (state_q)
      S_INIT: begin
        PC_clr  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // PC advances on the same edge that captures Instr, so IR holds the old-PC word.
        PC_up   = 1'b1;
        ir_d    = Instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          OP_NOOP:  state_d = S_NOOP;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP: state_d = S_FETCH;
      S_LOAD_A, S_LOAD_B: begin
        // LOAD_A covers the memory read latency; only LOAD_B commits the write.
        D_addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir_q[3:0];
        RF_W_en   = (state_q == S_LOAD_B);
        state_d   = (state_q == S_LOAD_A) ? S_LOAD_B : S_FETCH;
      end
      S_STORE: begin
        D_addr     = ir_q[7:0];
        RF_Ra_addr = ir_q[11:8];
        D_wr       = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_q[11:8];
        RF_Rb_addr = ir_q[7:4];
        RF_W_addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign IR_out = ir_q;
  assign State  = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized scoreboard bench for cpu_controller: stimulus pushes expected per-cycle
// outputs from an instruction-level model; a negedge monitor pops and compares.
module tb_cpu_controller;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ir;
    logic        pc_clr;
    logic        pc_up;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
    logic        halted;
  } obs_t;

  logic        Clock = 1'b0;
  logic        Clr = 1'b1;
  logic [15:0] Instr = '0;
  logic        PC_clr, PC_up, D_wr, RF_s, RF_W_en, Halted;
  logic [15:0] IR_out;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];

  // Model: current cycle's visible state number and IR, known after the first reset.
  int          cur_st = 0;
  logic [15:0] cur_ir = '0;
  bit          known = 1'b0;
  bit          done = 1'b0;

  cpu_controller #(.OPW(4), .IRW(16)) dut (
    .Clock(Clock), .Clr(Clr), .Instr(Instr),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_out(IR_out),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .Halted(Halted), .State(State)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got st=%0d ir=%h strobes=%h, want st=%0d ir=%h strobes=%h",
               name, $time, act.st, act.ir, act[28:0], exp.st, exp.ir, exp[28:0]);
    end
  endtask

  // Outputs each state must show, written straight from the state/strobe table.
  function automatic obs_t expect_of(input int st, input logic [15:0] ir);
    obs_t o;
    o    = '0;
    o.st = st[3:0];
    o.ir = ir;
    case (st)
      0: o.pc_clr = 1'b1;
      1: o.pc_up  = 1'b1;
      4, 5: begin
        o.d_addr = ir[11:4];
        o.rf_s   = 1'b1;
        o.w_addr = ir[3:0];
        o.w_en   = (st == 5);
      end
      6: begin
        o.d_addr = ir[7:0];
        o.ra     = ir[11:8];
        o.d_wr   = 1'b1;
      end
      7, 8: begin
        o.ra     = ir[11:8];
        o.rb     = ir[7:4];
        o.w_addr = ir[3:0];
        o.w_en   = 1'b1;
        o.alu    = (st == 7) ? 3'd1 : 3'd2;
      end
      9: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // One clock: expect current outputs, drive inputs, take the edge, advance the model.
  task automatic step(input logic clr, input logic [15:0] instr, input int nxt);
    if (known) exp_q.push_back(expect_of(cur_st, cur_ir));
    Clr   = clr;
    Instr = instr;
    @(posedge Clock);
    #1;
    if (clr) begin
      cur_st = 0;
      cur_ir = '0;
      known  = 1'b1;
    end else begin
      if (cur_st == 1) cur_ir = instr;
      cur_st = nxt;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'($urandom), 0);
    Clr = 1'b0;
  endtask

  task automatic init_step();
    step(1'b0, 16'($urandom), 1);
  endtask

  // Runs one instruction from FETCH; abort_at indexes the cycle in which Clr is raised.
  task automatic exec_instr(input logic [15:0] instr, input int abort_at);
    int seq[$];
    int nxt;
    seq = '{1, 2};
    case (instr[15:12])
      4'h1: seq.push_back(6);
      4'h2: begin seq.push_back(4); seq.push_back(5); end
      4'h3: seq.push_back(7);
      4'h4: seq.push_back(8);
      4'h5: seq.push_back(9);
      default: seq.push_back(3);
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i + 1 < seq.size()) nxt = seq[i+1];
      else nxt = (instr[15:12] == 4'h5) ? 9 : 1;
      if (i == abort_at) begin
        step(1'b1, 16'($urandom), 0);
        Clr = 1'b0;
        return;
      end
      step(1'b0, (i == 0) ? instr : 16'($urandom), nxt);
    end
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 9);
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      obs_t act;
      act = {State, IR_out, PC_clr, PC_up, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted};
      check("cycle", act, exp_q.pop_front());
    end
  end

  initial begin
    logic [15:0] w;
    int          ab;
    @(posedge Clock);
    #1;
    do_reset(2);
    init_step();
    exec_instr(16'h2A53, -1);
    exec_instr(16'h137F, -1);
    exec_instr(16'h3125, -1);
    exec_instr(16'h4125, -1);
    exec_instr(16'hF000, -1);
    exec_instr(16'h0000, -1);
    exec_instr(16'h5000, -1);
    hold_halt(19);
    do_reset(1);
    init_step();
    exec_instr(16'h2A53, 2);
    init_step();
    exec_instr(16'h3FFF, -1);

    for (int n = 0; n < 300; n++) begin
      w  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'h2;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      exec_instr(w, ab);
      if (cur_st == 9) begin
        hold_halt(int'($urandom_range(0, 5)));
        do_reset(int'($urandom_range(1, 3)));
      end
      if (cur_st == 0) init_step();
    end

    @(negedge Clock);
    #1;
    done = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no end of stimulus, want completion before 200000");
      $fatal(1);
    end
  end

endmodule
